// File: rtl/y_chk_pkg.sv
// Shared types and defaults for the MISR response checker.
// Holds the run-state encoding and the default width/polynomial constants.
package y_chk_pkg;

  localparam int Y_W_DEF   = 127;
  localparam int CNT_W_DEF = 16;

  // x^127 + x + 1: feedback taps at bits 0 and 1
  localparam logic [126:0] POLY_127 = 127'h3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/misr_reg.sv
// Signature register of the checker: a Galois-style MISR that folds one Y_W-bit
// sample per enabled clock, with a synchronous load back to SEED.
module misr_reg #(
  parameter int             Y_W  = 127,
  parameter logic [Y_W-1:0] POLY = Y_W'(3),
  parameter logic [Y_W-1:0] SEED = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           en_i,
  input  logic [Y_W-1:0] y_i,
  output logic [Y_W-1:0] sig_o
);

  logic [Y_W-1:0] sig_q;
  logic [Y_W-1:0] sig_d;

  // NOTE: sig_d is assigned its hold value first so every path drives it and no latch is inferred.
  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      // The bit shifted out of the top is consumed by the feedback, then dropped.
      sig_d = {sig_q[Y_W-2:0], 1'b0} ^ (sig_q[Y_W-1] ? POLY : '0) ^ y_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/y_misr_checker.sv
// Synthesizable response checker: compacts num_samples valid y vectors into a MISR
// signature, then compares it once against exp_sig and holds the verdict.
module y_misr_checker
  import y_chk_pkg::*;
#(
  parameter int             Y_W   = Y_W_DEF,
  parameter int             CNT_W = CNT_W_DEF,
  parameter logic [Y_W-1:0] POLY  = Y_W'(POLY_127),
  parameter logic [Y_W-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             y_valid,
  input  logic [Y_W-1:0]   y,
  input  logic [Y_W-1:0]   exp_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [Y_W-1:0]   sig,
  output logic [CNT_W-1:0] sample_cnt
);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             misr_load;
  logic             misr_en;

  misr_reg #(
    .Y_W  (Y_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .load_i (misr_load),
    .en_i   (misr_en),
    .y_i    (y),
    .sig_o  (sig)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    done_d    = done_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d     = num_samples;
          cnt_d     = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          misr_load = 1'b1;
          state_d   = (num_samples == '0) ? S_CHECK : S_RUN;
        end
      end
      S_RUN: begin
        // abort beats a coincident sample: nothing is folded or counted
        if (abort) begin
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else if (y_valid) begin
          misr_en = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_d == num_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          pass_d  = (sig == exp_sig);
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign sample_cnt = cnt_q;

endmodule
